// File: rtl/fractal_pkg.sv
// fractal_pkg: shared types and helpers for the fractal stream generator.
//   fsm_state_e  - controller states (IDLE, INIT, ITERATE, OUTPUT)
//   ESCAPE_R2    - escape radius squared (4.0) in the default Q4.28 format
//   escape_r2()  - 4.0 scaled to an arbitrary number of fractional bits
//   colour_map() - iteration count to {R, G, B}
package fractal_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_INIT    = 2'd1,
    ST_ITERATE = 2'd2,
    ST_OUTPUT  = 2'd3
  } fsm_state_e;

  localparam int DEF_FRAC_W = 28;

  // 4.0 expressed with frac_w fractional bits
  function automatic logic [63:0] escape_r2(input int frac_w);
    return 64'd4 << frac_w;
  endfunction

  localparam logic [63:0] ESCAPE_R2 = 64'd4 << DEF_FRAC_W;

  // Escaped pixels: R=2*iter, G=3*iter (both mod 256), B=0xFF; interior is black
  function automatic logic [23:0] colour_map(input logic [7:0] iter8, input logic escaped);
    logic [23:0] rgb;
    if (escaped) begin
      rgb = {8'(iter8 << 1), 8'(iter8 * 8'd3), 8'hFF};
    end else begin
      rgb = 24'h000000;
    end
    return rgb;
  endfunction

endpackage

// File: rtl/fractal_iter_step.sv
// fractal_iter_step: one combinational z -> z^2 + c step with escape test.
//   zr, zi    in   current z (signed fixed point, FRAC_W fractional bits)
//   cr, ci    in   constant c
//   zr_next,  out  zr^2 - zi^2 + cr   (wraps silently)
//   zi_next   out  2*zr*zi + ci       (wraps silently)
//   escape    out  zr^2 + zi^2 > 4.0 on the current z
module fractal_iter_step
  import fractal_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 28
) (
  input  logic [DATA_W-1:0] zr,
  input  logic [DATA_W-1:0] zi,
  input  logic [DATA_W-1:0] cr,
  input  logic [DATA_W-1:0] ci,
  output logic [DATA_W-1:0] zr_next,
  output logic [DATA_W-1:0] zi_next,
  output logic              escape
);

  localparam int PW = 2 * DATA_W;
  localparam logic [63:0] ESC_THRESH = (FRAC_W == DEF_FRAC_W) ? ESCAPE_R2 : escape_r2(FRAC_W);
  localparam logic [DATA_W+1:0] ESC_LIMIT = (DATA_W + 2)'(ESC_THRESH);

  logic signed [PW-1:0] zr_x_s;
  logic signed [PW-1:0] zi_x_s;
  logic signed [PW-1:0] p_rr_s;
  logic signed [PW-1:0] p_ii_s;
  logic signed [PW-1:0] p_ri_s;
  logic signed [PW-1:0] sq_rr_s;
  logic signed [PW-1:0] sq_ii_s;
  logic [DATA_W:0]      sat_rr_s;
  logic [DATA_W:0]      sat_ii_s;
  logic [DATA_W+1:0]    mag_s;

  // Full-width signed products, rescaled to FRAC_W fractional bits
  assign zr_x_s  = PW'($signed(zr));
  assign zi_x_s  = PW'($signed(zi));
  assign p_rr_s  = zr_x_s * zr_x_s;
  assign p_ii_s  = zi_x_s * zi_x_s;
  assign p_ri_s  = zr_x_s * zi_x_s;
  assign sq_rr_s = p_rr_s >>> FRAC_W;
  assign sq_ii_s = p_ii_s >>> FRAC_W;

  // Squares are non-negative; clamping each to DATA_W+1 bits keeps the
  // DATA_W+2 bit sum from wrapping while staying well above 4.0
  assign sat_rr_s = (|sq_rr_s[PW-1:DATA_W+1]) ? {(DATA_W + 1){1'b1}} : sq_rr_s[DATA_W:0];
  assign sat_ii_s = (|sq_ii_s[PW-1:DATA_W+1]) ? {(DATA_W + 1){1'b1}} : sq_ii_s[DATA_W:0];
  assign mag_s    = {1'b0, sat_rr_s} + {1'b0, sat_ii_s};
  assign escape   = (mag_s > ESC_LIMIT);

  // Shifting by FRAC_W-1 folds the factor of 2 into the rescale
  assign zr_next = DATA_W'(sq_rr_s - sq_ii_s) + cr;
  assign zi_next = DATA_W'(p_ri_s >>> (FRAC_W - 1)) + ci;

endmodule

// File: rtl/fractal_stream_gen.sv
// fractal_stream_gen: renders Julia / Mandelbrot frames as an AXI-Stream of
// 32-bit pixels {8'h00, R, G, B}, one escape-time iteration per cycle.
//   out_stream_aclk, periph_reset   clock, async active-high reset
//   enable                          run frames (sampled at frame boundaries)
//   mode                            0 = Julia, 1 = Mandelbrot
//   c_re, c_im                      Julia constant
//   x_start, y_start                top-left coordinate
//   step_x, step_y                  per-pixel / per-line increment
//   max_iter                        iteration limit
//   out_stream_t*                   AXI-Stream master (tuser = start of frame,
//                                   tlast = end of line)
//   busy                            frame in progress
//   frame_done                      one-cycle pulse after the last transfer
module fractal_stream_gen
  import fractal_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 28,
  parameter int ITER_W = 8,
  parameter int X_SIZE = 640,
  parameter int Y_SIZE = 480
) (
  input  logic              out_stream_aclk,
  input  logic              periph_reset,
  input  logic              enable,
  input  logic              mode,
  input  logic [DATA_W-1:0] c_re,
  input  logic [DATA_W-1:0] c_im,
  input  logic [DATA_W-1:0] x_start,
  input  logic [DATA_W-1:0] y_start,
  input  logic [DATA_W-1:0] step_x,
  input  logic [DATA_W-1:0] step_y,
  input  logic [ITER_W-1:0] max_iter,
  output logic [31:0]       out_stream_tdata,
  output logic              out_stream_tvalid,
  output logic              out_stream_tlast,
  output logic [3:0]        out_stream_tkeep,
  output logic              out_stream_tuser,
  input  logic              out_stream_tready,
  output logic              busy,
  output logic              frame_done
);

  localparam int X_W = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
  localparam int Y_W = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;
  localparam logic [X_W-1:0] X_LAST = X_W'(X_SIZE - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(Y_SIZE - 1);

  fsm_state_e state_r;
  fsm_state_e state_next_s;

  // Per-frame configuration snapshot
  logic              mode_r;
  logic [DATA_W-1:0] c_re_r;
  logic [DATA_W-1:0] c_im_r;
  logic [DATA_W-1:0] x_start_r;
  logic [DATA_W-1:0] step_x_r;
  logic [DATA_W-1:0] step_y_r;
  logic [ITER_W-1:0] max_iter_r;

  // Pixel position and accumulated coordinate
  logic [X_W-1:0]    x_r;
  logic [Y_W-1:0]    y_r;
  logic [DATA_W-1:0] cx_r;
  logic [DATA_W-1:0] cy_r;

  // Iteration state
  logic [DATA_W-1:0] zr_r;
  logic [DATA_W-1:0] zi_r;
  logic [DATA_W-1:0] cr_r;
  logic [DATA_W-1:0] ci_r;
  logic [ITER_W-1:0] iter_r;
  logic [DATA_W-1:0] zr_next_s;
  logic [DATA_W-1:0] zi_next_s;
  logic              escape_s;

  // Registered stream outputs
  logic [31:0] tdata_r;
  logic        tvalid_r;
  logic        tlast_r;
  logic        tuser_r;
  logic        busy_r;
  logic        frame_done_r;

  logic iter_done_s;
  logic xfer_s;
  logic line_end_s;
  logic frame_end_s;
  logic load_frame_s;

  fractal_iter_step #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W)
  ) u_iter_step (
    .zr      (zr_r),
    .zi      (zi_r),
    .cr      (cr_r),
    .ci      (ci_r),
    .zr_next (zr_next_s),
    .zi_next (zi_next_s),
    .escape  (escape_s)
  );

  assign iter_done_s  = escape_s || (iter_r == max_iter_r);
  assign xfer_s       = (state_r == ST_OUTPUT) && out_stream_tready;
  assign line_end_s   = (x_r == X_LAST);
  assign frame_end_s  = line_end_s && (y_r == Y_LAST);
  // A frame starts from IDLE, or back-to-back after the last transfer
  assign load_frame_s = enable && ((state_r == ST_IDLE) || (xfer_s && frame_end_s));

  // Controller next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (enable) begin
          state_next_s = ST_INIT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_INIT: begin
        state_next_s = ST_ITERATE;
      end
      ST_ITERATE: begin
        if (iter_done_s) begin
          state_next_s = ST_OUTPUT;
        end else begin
          state_next_s = ST_ITERATE;
        end
      end
      ST_OUTPUT: begin
        if (!xfer_s) begin
          state_next_s = ST_OUTPUT;
        end else if (frame_end_s && !enable) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_INIT;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Controller state register
  always_ff @(posedge out_stream_aclk or posedge periph_reset) begin
    if (periph_reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Configuration snapshot, taken only when a frame starts
  always_ff @(posedge out_stream_aclk or posedge periph_reset) begin
    if (periph_reset) begin
      mode_r     <= 1'b0;
      c_re_r     <= '0;
      c_im_r     <= '0;
      x_start_r  <= '0;
      step_x_r   <= '0;
      step_y_r   <= '0;
      max_iter_r <= '0;
    end else if (load_frame_s) begin
      mode_r     <= mode;
      c_re_r     <= c_re;
      c_im_r     <= c_im;
      x_start_r  <= x_start;
      step_x_r   <= step_x;
      step_y_r   <= step_y;
      max_iter_r <= max_iter;
    end
  end

  // Pixel walk: coordinates are accumulated, never multiplied out
  always_ff @(posedge out_stream_aclk or posedge periph_reset) begin
    if (periph_reset) begin
      x_r  <= '0;
      y_r  <= '0;
      cx_r <= '0;
      cy_r <= '0;
    end else if (load_frame_s) begin
      x_r  <= '0;
      y_r  <= '0;
      cx_r <= x_start;
      cy_r <= y_start;
    end else if (xfer_s && !frame_end_s) begin
      if (line_end_s) begin
        x_r  <= '0;
        y_r  <= y_r + Y_W'(1);
        cx_r <= x_start_r;
        cy_r <= cy_r + step_y_r;
      end else begin
        x_r  <= x_r + X_W'(1);
        cx_r <= cx_r + step_x_r;
      end
    end
  end

  // Escape-time iteration; Julia seeds z with the pixel, Mandelbrot seeds c
  always_ff @(posedge out_stream_aclk or posedge periph_reset) begin
    if (periph_reset) begin
      zr_r   <= '0;
      zi_r   <= '0;
      cr_r   <= '0;
      ci_r   <= '0;
      iter_r <= '0;
    end else if (state_r == ST_INIT) begin
      iter_r <= '0;
      if (mode_r) begin
        zr_r <= '0;
        zi_r <= '0;
        cr_r <= cx_r;
        ci_r <= cy_r;
      end else begin
        zr_r <= cx_r;
        zi_r <= cy_r;
        cr_r <= c_re_r;
        ci_r <= c_im_r;
      end
    end else if ((state_r == ST_ITERATE) && !iter_done_s) begin
      zr_r   <= zr_next_s;
      zi_r   <= zi_next_s;
      iter_r <= iter_r + ITER_W'(1);
    end
  end

  // Stream outputs, busy and frame_done; pixel is held until accepted
  always_ff @(posedge out_stream_aclk or posedge periph_reset) begin
    if (periph_reset) begin
      tdata_r      <= 32'h0000_0000;
      tvalid_r     <= 1'b0;
      tlast_r      <= 1'b0;
      tuser_r      <= 1'b0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      busy_r       <= (state_next_s != ST_IDLE);
      frame_done_r <= xfer_s && frame_end_s;
      if ((state_r == ST_ITERATE) && iter_done_s) begin
        // max_iter of zero always yields an interior pixel
        tdata_r  <= {8'h00, colour_map(8'(iter_r), escape_s && (max_iter_r != '0))};
        tvalid_r <= 1'b1;
        tlast_r  <= line_end_s;
        tuser_r  <= (x_r == '0) && (y_r == '0);
      end else if (xfer_s) begin
        tvalid_r <= 1'b0;
        tlast_r  <= 1'b0;
        tuser_r  <= 1'b0;
      end
    end
  end

  assign out_stream_tdata  = tdata_r;
  assign out_stream_tvalid = tvalid_r;
  assign out_stream_tlast  = tlast_r;
  assign out_stream_tuser  = tuser_r;
  assign out_stream_tkeep  = 4'hF;
  assign busy              = busy_r;
  assign frame_done        = frame_done_r;

endmodule

// File: tb/tb_fractal_stream_gen.sv
module tb_fractal_stream_gen;

  localparam logic [31:0] ONE     = 32'h1000_0000;
  localparam logic [31:0] ONE_P5  = 32'h1800_0000;
  localparam logic [31:0] TWO_P5  = 32'h2800_0000;
  localparam logic [31:0] M_TWO   = 32'hE000_0000;
  localparam logic [31:0] M_TWO_P5 = 32'hD800_0000;

  logic        clk = 1'b0;
  logic        periph_reset;
  logic        enable;
  logic        mode;
  logic [31:0] c_re, c_im, x_start, y_start, step_x, step_y;
  logic [7:0]  max_iter;
  logic [31:0] out_stream_tdata;
  logic        out_stream_tvalid, out_stream_tlast, out_stream_tuser;
  logic [3:0]  out_stream_tkeep;
  logic        tready;
  logic        busy, frame_done;

  always #5 clk = ~clk;

  fractal_stream_gen #(
    .DATA_W(32), .FRAC_W(28), .ITER_W(8), .X_SIZE(4), .Y_SIZE(2)
  ) dut (
    .out_stream_aclk   (clk),
    .periph_reset      (periph_reset),
    .enable            (enable),
    .mode              (mode),
    .c_re              (c_re),
    .c_im              (c_im),
    .x_start           (x_start),
    .y_start           (y_start),
    .step_x            (step_x),
    .step_y            (step_y),
    .max_iter          (max_iter),
    .out_stream_tdata  (out_stream_tdata),
    .out_stream_tvalid (out_stream_tvalid),
    .out_stream_tlast  (out_stream_tlast),
    .out_stream_tkeep  (out_stream_tkeep),
    .out_stream_tuser  (out_stream_tuser),
    .out_stream_tready (tready),
    .busy              (busy),
    .frame_done        (frame_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        mode;
    logic [31:0] xs;
    logic [31:0] ys;
    logic [31:0] cre;
    logic [31:0] cim;
    logic [7:0]  mi;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vecs[8];

  logic [31:0] cap_data[16];
  logic        cap_user[16];
  logic        cap_last[16];
  int          cap_n, fd_count, fd_cycle, last_xfer_cycle;

  logic [31:0] exp_a[8];

  task automatic do_reset();
    periph_reset = 1'b1;
    enable = 1'b0;
    tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    periph_reset = 1'b0;
  endtask

  task automatic set_cfg(input logic m, input logic [31:0] xs, input logic [31:0] ys,
                         input logic [31:0] sx, input logic [31:0] sy,
                         input logic [31:0] cre, input logic [31:0] cim, input logic [7:0] mi);
    mode = m; x_start = xs; y_start = ys; step_x = sx; step_y = sy;
    c_re = cre; c_im = cim; max_iter = mi;
  endtask

  // Runs 'run' cycles, recording up to n transfers; optionally stalls pixel stall_px for 5 cycles
  task automatic capture(input int n, input int stall_px, input int run);
    int stall_cnt;
    logic [31:0] held;
    stall_cnt = 0;
    held = 32'h0;
    cap_n = 0; fd_count = 0; fd_cycle = -1; last_xfer_cycle = -1;
    for (int i = 0; i < 16; i++) begin
      cap_data[i] = 32'hDEAD_BEEF; cap_user[i] = 1'b0; cap_last[i] = 1'b0;
    end
    for (int cyc = 1; cyc <= run; cyc++) begin
      @(posedge clk);
      #1;
      if (frame_done) begin
        fd_count++;
        if (fd_cycle < 0) fd_cycle = cyc;
      end
      if (stall_cnt >= 1 && stall_cnt <= 4) begin
        chk("stall_tvalid", 32'(out_stream_tvalid), 32'd1);
        chk("stall_tdata", out_stream_tdata, held);
        stall_cnt++;
        tready = 1'b0;
      end else if (out_stream_tvalid && cap_n < n) begin
        if (cap_n == stall_px && stall_cnt == 0) begin
          held = out_stream_tdata;
          stall_cnt = 1;
          tready = 1'b0;
        end else begin
          tready = 1'b1;
          cap_data[cap_n] = out_stream_tdata;
          cap_user[cap_n] = out_stream_tuser;
          cap_last[cap_n] = out_stream_tlast;
          cap_n++;
          last_xfer_cycle = cyc;
        end
      end else begin
        tready = 1'b1;
      end
    end
    tready = 1'b1;
  endtask

  initial begin
    int b, v;
    vecs[0] = '{1'b0, 32'h0,  32'h0,  32'h0, 32'h0, 8'd16, 32'h0000_0000, 18};
    vecs[1] = '{1'b0, TWO_P5, 32'h0,  32'h0, 32'h0, 8'd16, 32'h0000_00FF, 2};
    vecs[2] = '{1'b1, ONE,    32'h0,  32'h0, 32'h0, 8'd16, 32'h0006_09FF, 5};
    vecs[3] = '{1'b0, TWO_P5, 32'h0,  32'h0, 32'h0, 8'd0,  32'h0000_0000, 2};
    vecs[4] = '{1'b0, 32'h0,  32'h0,  32'h0, 32'h0, 8'd5,  32'h0000_0000, 7};
    vecs[5] = '{1'b1, M_TWO,  32'h0,  32'h0, 32'h0, 8'd10, 32'h0000_0000, 12};
    vecs[6] = '{1'b0, 32'h0,  ONE_P5, 32'h0, 32'h0, 8'd16, 32'h0002_03FF, 3};
    vecs[7] = '{1'b0, ONE_P5, ONE_P5, 32'h0, 32'h0, 8'd16, 32'h0000_00FF, 2};

    exp_a[0] = 32'h0000_0000; exp_a[1] = 32'h0000_0000;
    exp_a[2] = 32'h0002_03FF; exp_a[3] = 32'h0000_00FF;
    exp_a[4] = 32'h0000_0000; exp_a[5] = 32'h0004_06FF;
    exp_a[6] = 32'h0000_00FF; exp_a[7] = 32'h0000_00FF;

    set_cfg(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 8'd16);
    do_reset();

    // Reset state
    chk("rst_tvalid", 32'(out_stream_tvalid), 32'd0);
    chk("rst_tdata", out_stream_tdata, 32'h0);
    chk("rst_tlast", 32'(out_stream_tlast), 32'd0);
    chk("rst_tuser", 32'(out_stream_tuser), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("tkeep", 32'(out_stream_tkeep), 32'hF);

    // Table-driven first-pixel checks: colour and INIT-to-tvalid latency
    for (int i = 0; i < 8; i++) begin
      do_reset();
      set_cfg(vecs[i].mode, vecs[i].xs, vecs[i].ys, 32'h0, 32'h0, vecs[i].cre, vecs[i].cim, vecs[i].mi);
      enable = 1'b1;
      b = -1;
      v = -1;
      for (int cyc = 1; cyc <= 60 && v < 0; cyc++) begin
        @(posedge clk);
        #1;
        if (busy && b < 0) b = cyc;
        if (out_stream_tvalid) v = cyc;
      end
      chk($sformatf("vec%0d_tvalid_seen", i), 32'(v > 0), 32'd1);
      chk($sformatf("vec%0d_tdata", i), out_stream_tdata, vecs[i].exp_data);
      chk($sformatf("vec%0d_latency", i), 32'(v - b), 32'(vecs[i].exp_lat));
      chk($sformatf("vec%0d_tuser", i), 32'(out_stream_tuser), 32'd1);
      chk($sformatf("vec%0d_tlast", i), 32'(out_stream_tlast), 32'd0);
    end

    // Full 4x2 frame, tready high, enable dropped after start
    do_reset();
    set_cfg(1'b0, 32'h0, 32'h0, ONE, ONE, 32'h0, 32'h0, 8'd16);
    enable = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    enable = 1'b0;
    capture(8, -1, 300);
    chk("A_count", 32'(cap_n), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("A_px%0d", i), cap_data[i], exp_a[i]);
      chk($sformatf("A_tuser%0d", i), 32'(cap_user[i]), 32'(i == 0));
      chk($sformatf("A_tlast%0d", i), 32'(cap_last[i]), 32'(i == 3 || i == 7));
    end
    chk("A_frame_done_count", 32'(fd_count), 32'd1);
    chk("A_frame_done_timing", 32'(fd_cycle), 32'(last_xfer_cycle + 1));
    chk("A_busy_end", 32'(busy), 32'd0);
    chk("A_tvalid_end", 32'(out_stream_tvalid), 32'd0);

    // Same frame with a 5-cycle tready stall on pixel 2
    do_reset();
    set_cfg(1'b0, 32'h0, 32'h0, ONE, ONE, 32'h0, 32'h0, 8'd16);
    enable = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    enable = 1'b0;
    capture(8, 2, 300);
    chk("B_count", 32'(cap_n), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("B_px%0d", i), cap_data[i], exp_a[i]);
    end
    chk("B_frame_done_count", 32'(fd_count), 32'd1);

    // c_re changed mid-frame: only the next frame sees it
    do_reset();
    set_cfg(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 8'd4);
    enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    c_re = TWO_P5;
    capture(9, -1, 300);
    chk("C_count", 32'(cap_n), 32'd9);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("C_px%0d", i), cap_data[i], 32'h0000_0000);
    end
    chk("C_next_frame_px0", cap_data[8], 32'h0002_03FF);
    chk("C_next_frame_tuser", 32'(cap_user[8]), 32'd1);
    enable = 1'b0;

    // Reset pulse mid-ITERATE of pixel 1
    do_reset();
    set_cfg(1'b0, TWO_P5, 32'h0, M_TWO_P5, 32'h0, 32'h0, 32'h0, 8'd16);
    enable = 1'b1;
    capture(1, -1, 6);
    chk("D_px0", cap_data[0], 32'h0000_00FF);
    chk("D_busy_before", 32'(busy), 32'd1);
    periph_reset = 1'b1;
    #1;
    chk("D_rst_tvalid", 32'(out_stream_tvalid), 32'd0);
    chk("D_rst_tdata", out_stream_tdata, 32'h0);
    chk("D_rst_tuser", 32'(out_stream_tuser), 32'd0);
    chk("D_rst_tlast", 32'(out_stream_tlast), 32'd0);
    chk("D_rst_busy", 32'(busy), 32'd0);
    chk("D_rst_frame_done", 32'(frame_done), 32'd0);
    @(posedge clk);
    #1;
    periph_reset = 1'b0;
    capture(1, -1, 10);
    chk("D_restart_count", 32'(cap_n), 32'd1);
    chk("D_restart_px", cap_data[0], 32'h0000_00FF);
    chk("D_restart_tuser", 32'(cap_user[0]), 32'd1);
    enable = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fractal_stream_gen.md
FRACTAL_STREAM_GEN -- requirements
Module: fractal_stream_gen

Interface
REQ-001 The module SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-002 Parameter DATA_W, default 32: signed fixed-point coordinate width.
REQ-003 Parameter FRAC_W, default 28: fractional bits (Q4.28 at defaults).
REQ-004 Parameter ITER_W, default 8: iteration counter width.
REQ-005 Parameter X_SIZE, default 640: pixels per line.
REQ-006 Parameter Y_SIZE, default 480: lines per frame.
REQ-007 out_stream_aclk  in  1  clock.
REQ-008 periph_reset  in  1  asynchronous active-high reset.
REQ-009 enable  in  1  run frames; sampled at frame boundaries.
REQ-010 mode  in  1  0 = Julia, 1 = Mandelbrot.
REQ-011 c_re, c_im  in  DATA_W each  Julia constant.
REQ-012 x_start, y_start  in  DATA_W each  top-left coordinate.
REQ-013 step_x, step_y  in  DATA_W each  per-pixel and per-line increment.
REQ-014 max_iter  in  ITER_W  iteration limit.
REQ-015 out_stream_tdata  out  32  pixel {8'h00, R, G, B}.
REQ-016 out_stream_tvalid, out_stream_tlast  out  1 each  AXI-Stream valid; end of line.
REQ-017 out_stream_tkeep  out  4  constant 4'hF.
REQ-018 out_stream_tuser  out  1  start of frame.
REQ-019 out_stream_tready  in  1  sink ready.
REQ-020 busy  out  1  frame in progress.
REQ-021 frame_done  out  1  one-cycle pulse after the last pixel transfers.

Function
REQ-022 FSM states SHALL be IDLE, INIT, ITERATE, OUTPUT.
REQ-023 IDLE with enable=1 -> INIT; the frame starts: all config inputs latched, pixel (0,0), cx=x_start, cy=y_start.
- Config changes mid-frame have no effect until the next frame.
REQ-024 INIT, 1 cycle: iter=0; Julia z=(cx,cy), c=(c_re,c_im); Mandelbrot z=(0,0), c=(cx,cy).
REQ-025 ITERATE, 1 cycle per step, using the current z:
- Escape when zr^2+zi^2 > 4.0; the sum is computed at DATA_W+2 bits, with no wrap.
- If escaped, or iter==max_iter, go to OUTPUT.
- Otherwise: zr'=zr^2-zi^2+cr, zi'=2*zr*zi+ci, iter+1.
REQ-026 Products SHALL be full 2*DATA_W signed, arithmetically shifted right FRAC_W, then truncated to DATA_W. z updates wrap silently.
REQ-027 OUTPUT colour:
- Escaped: R=(2*iter) mod 256, G=(3*iter) mod 256, B=8'hFF.
- Not escaped (iter==max_iter): 0x000000.
- max_iter=0: pixel is interior.
REQ-028 OUTPUT SHALL assert tvalid and hold tdata, tlast and tuser stable until tready=1.
REQ-029 tuser=1 only on pixel (0,0); tlast=1 only when x==X_SIZE-1.
REQ-030 On transfer in OUTPUT:
- Not last pixel: advance and go to INIT. cx+=step_x; at line end x=0, cx=latched x_start, cy+=step_y, y+1.
- Last pixel: pulse frame_done next cycle. If enable=1 start a new frame (INIT, fresh latch); else go to IDLE.
REQ-031 Coordinates SHALL be produced by accumulation only, with no multiplier.
REQ-032 tvalid SHALL be 0 in IDLE, INIT and ITERATE.
REQ-033 busy SHALL be 1 in every state except IDLE.
REQ-034 Minimum per-pixel period SHALL be n+2 cycles (n = ITERATE cycles) with tready held high.

Reset
REQ-035 periph_reset SHALL immediately force: state IDLE, x=y=0, iter=0, tvalid=0, tlast=0, tuser=0, tdata=0, busy=0, frame_done=0; also mid-frame.
REQ-036 After reset release with enable=1, the first transfer SHALL be pixel (0,0) with tuser=1.

Structure
REQ-037 Package fractal_pkg SHALL hold the state enum, the ESCAPE_R2 constant (4.0 in Q format) and the colour-map function.
REQ-038 Sub-module fractal_iter_step (combinational: z, c -> z', escape) SHALL be instantiated once.

Verification (DATA_W=32, FRAC_W=28)
REQ-039 Julia: x_start=0, y_start=0, c=(0,0), max_iter=16 -> first tdata 0x00000000; tvalid rises 18 cycles after INIT entry.
REQ-040 Julia: x_start=0x28000000 (2.5), y_start=0, max_iter=16 -> escape at iter 0, tdata 0x000000FF.
REQ-041 Mandelbrot: x_start=0x10000000 (1.0), y_start=0 -> z 0,1,2,5; escape at iter 3, tdata 0x000609FF.
REQ-042 X_SIZE=4, Y_SIZE=2, tready=1 -> 8 transfers; tuser on transfer 0 only; tlast on transfers 3 and 7; single frame_done pulse; enable=0 -> IDLE, busy=0.
REQ-043 tready=0 for 5 cycles during OUTPUT -> tvalid and tdata held constant; no pixel lost or duplicated.
REQ-044 Edge cases:
- c_re changed mid-frame -> current frame unaffected, next frame uses the new value.
- periph_reset pulse mid-ITERATE -> all outputs 0 the same cycle; restart at (0,0) with tuser=1.
